// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide opcodes, FSM states and ALU control codes.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // ALU control codes issued by decode for HI/LO traffic
  localparam logic [4:0] ALU_CTL_DIV  = 5'd2;
  localparam logic [4:0] ALU_CTL_MULT = 5'd8;
  localparam logic [4:0] ALU_CTL_MTHI = 5'd16;
  localparam logic [4:0] ALU_CTL_MFHI = 5'd17;
  localparam logic [4:0] ALU_CTL_MTLO = 5'd18;
  localparam logic [4:0] ALU_CTL_MFLO = 5'd19;

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iteration engine: 2*WIDTH accumulator with one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle.
module mips_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opnd};
    div_shift = {acc, 1'b0};
    div_top   = div_shift[2*WIDTH:WIDTH];
    div_diff  = div_top - {1'b0, opnd};
    acc_next  = acc;
    if (!is_div)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_top >= {1'b0, opnd})
      acc_next = {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    else
      acc_next = {div_top[WIDTH-1:0], div_shift[WIDTH-1:0]};
  end

  // Multiplier / dividend sits in the low half; upper half holds partial product / remainder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, src_a};
      opnd <= src_b;
    end else if (step) begin
      acc  <= acc_next;
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
//   state | meaning
//   IDLE  | accepts start or MTHI/MTLO writes
//   RUN   | WIDTH iteration steps in the engine
//   FIX   | sign correction, HI/LO commit, done pulse
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] alu_src_1,
  input  logic [WIDTH-1:0] alu_src_2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state;
  muldiv_op_t         op_in, op_q;
  logic [CW-1:0]      count;
  logic               neg_a, neg_b, dz;
  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  logic               accept;

  always_comb begin
    op_in     = muldiv_op_t'(op);
    is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    a_abs     = (is_signed && alu_src_1[WIDTH-1]) ? -alu_src_1 : alu_src_1;
    b_abs     = (is_signed && alu_src_2[WIDTH-1]) ? -alu_src_2 : alu_src_2;
    accept    = (state == ST_IDLE) && start;
  end

  mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state == ST_RUN),
    .is_div (op_q[1]),
    .src_a  (a_abs),
    .src_b  (b_abs),
    .acc    (acc)
  );

  // Sign bits are only recorded for signed ops, so they double as fix-up enables
  always_comb begin
    prod   = (neg_a ^ neg_b) ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      res_hi = (!dz && neg_a) ? -rem : rem;
      res_lo = (!dz && (neg_a ^ neg_b)) ? -quo : quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_MULT;
      count       <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            neg_a <= is_signed && alu_src_1[WIDTH-1];
            neg_b <= is_signed && alu_src_2[WIDTH-1];
            dz    <= op_in[1] && (alu_src_2 == '0);
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            if (mthi) hi <= alu_src_1;
            if (mtlo) lo <= alu_src_1;
          end
        end
        ST_RUN: begin
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dz;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: vector table plus hand-written multi-cycle sequences.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] alu_src_1, alu_src_2;
  logic        mthi, mtlo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int failed = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .alu_src_1(alu_src_1), .alu_src_2(alu_src_2),
    .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (edge N); returns just after edge N
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; alu_src_1 = a; alu_src_2 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done counting edges after N; done must appear after edge N+33
  task automatic wait_done(input string name, output int k);
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check({name, " latency"}, 64'(k), 64'd33);
  endtask

  int k;

  initial begin
    vecs[0]  = '{2'b11, 32'h11111111, 32'h00000088, 32'h00000011, 32'h00202020, 1'b0};
    vecs[1]  = '{2'b01, 32'h11111111, 32'h00000088, 32'h00000009, 32'h11111108, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[4]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[11] = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};

    reset = 1'b1; start = 1'b0; op = 2'b00; alu_src_1 = '0; alu_src_2 = '0;
    mthi = 1'b0; mtlo = 1'b0;
    tick(); tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    // MTHI alone, then MTHI+MTLO together
    alu_src_1 = 32'd6; mthi = 1'b1; tick(); mthi = 1'b0;
    check("mthi", {hi, lo}, {32'd6, 32'd0});
    alu_src_1 = 32'd9; mthi = 1'b1; mtlo = 1'b1; tick(); mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo", {hi, lo}, {32'd9, 32'd9});

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy", i), 64'(busy), 64'd1);
      wait_done($sformatf("v%0d", i), k);
      check($sformatf("v%0d hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("v%0d dz", i), 64'(div_by_zero), 64'(vecs[i].exp_dz));
      check($sformatf("v%0d busy off", i), 64'(busy), 64'd0);
      tick();
      check($sformatf("v%0d done pulse", i), {63'd0, done}, 64'd0);
      check($sformatf("v%0d dz pulse", i), {63'd0, div_by_zero}, 64'd0);
    end

    // Preload HI/LO, then start with MTHI/MTLO in the same cycle: writes dropped
    alu_src_1 = 32'h55; mthi = 1'b1; mtlo = 1'b1; tick();
    op = 2'b01; alu_src_1 = 32'd2; alu_src_2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("start wins", {hi, lo}, {32'h55, 32'h55});
    k = 0;
    while (!done && k < 40) begin
      if (k == 4) begin alu_src_1 = 32'hDEAD; mthi = 1'b1; end
      if (k == 5) mthi = 1'b0;
      if (k == 9) begin op = 2'b11; alu_src_1 = 32'd100; alu_src_2 = 32'd0; start = 1'b1; end
      if (k == 10) start = 1'b0;
      tick();
      k++;
      if (k == 6) check("mthi busy ignored", 64'(hi), 64'h55);
    end
    check("ignore latency", 64'(k), 64'd33);
    check("ignore result", {hi, lo}, {32'd0, 32'd6});
    check("ignore no dz", 64'(div_by_zero), 64'd0);
    tick();
    check("second start ignored", 64'(busy), 64'd0);

    // Reset mid-operation discards the divide
    issue(2'b10, 32'd1000, 32'd7);
    repeat (14) tick();
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) k++;
    end
    check("midreset no done", 64'(k), 64'd0);
    issue(2'b10, 32'd1000, 32'd7);
    wait_done("post reset", k);
    check("post reset hilo", {hi, lo}, {32'd6, 32'd142});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
